// File: rtl/aes_sbox_arbiter_if.sv
// Request, S-box and response signals shared between the two AES requesters,
// the external S-box and the arbiter that multiplexes them.
interface aes_sbox_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_inv;
    logic       req0_ready;

    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_inv;
    logic       req1_ready;

    logic [7:0] sbox_in;
    logic       sbox_inv;
    logic [7:0] sbox_out;

    logic       rsp0_valid;
    logic       rsp1_valid;
    logic [7:0] rsp_data;

    logic       flush;
    logic       busy;

    // Requesters plus the external S-box drive this side
    modport master (
        output req0_valid, req0_data, req0_inv,
        input  req0_ready,
        output req1_valid, req1_data, req1_inv,
        input  req1_ready,
        input  sbox_in, sbox_inv,
        output sbox_out,
        input  rsp0_valid, rsp1_valid, rsp_data,
        output flush,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_data, req0_inv,
        output req0_ready,
        input  req1_valid, req1_data, req1_inv,
        output req1_ready,
        output sbox_in, sbox_inv,
        input  sbox_out,
        output rsp0_valid, rsp1_valid, rsp_data,
        input  flush,
        output busy
    );
endinterface

// File: rtl/aes_sbox_arbiter.sv
// Round-robin arbiter sharing one pipelined S-box between the round datapath
// (port 0) and key expansion (port 1); results are routed back by port id.
module aes_sbox_arbiter #(
    parameter int SBOX_LAT = 2
) (
    input logic               clk,
    input logic               rst,
    aes_sbox_arbiter_if.slave bus
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e               last_q;
    port_e               last_d;
    logic [SBOX_LAT-1:0] trk_valid_q;
    logic [SBOX_LAT-1:0] trk_valid_d;
    logic [SBOX_LAT-1:0] trk_port_q;
    logic [SBOX_LAT-1:0] trk_port_d;

    logic  grant0;
    logic  grant1;
    logic  grant;
    port_e grant_port;
    logic  tail_valid;

    // A tie goes to whichever port did not win the most recent grant
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !bus.flush) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_q == PORT0) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else if (bus.req0_valid) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
        grant      = grant0 | grant1;
        grant_port = grant1 ? PORT1 : PORT0;
        last_d     = grant ? grant_port : last_q;
    end

    always_comb begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        bus.sbox_in    = 8'h00;
        bus.sbox_inv   = 1'b0;
        if (grant0) begin
            bus.sbox_in  = bus.req0_data;
            bus.sbox_inv = bus.req0_inv;
        end else if (grant1) begin
            bus.sbox_in  = bus.req1_data;
            bus.sbox_inv = bus.req1_inv;
        end
    end

    // Tracking pipe mirrors the S-box pipe so the tail lines up with sbox_out
    always_comb begin
        trk_valid_d    = '0;
        trk_port_d     = '0;
        trk_valid_d[0] = grant;
        trk_port_d[0]  = grant_port;
        for (int i = 1; i < SBOX_LAT; i++) begin
            trk_valid_d[i] = trk_valid_q[i-1];
            trk_port_d[i]  = trk_port_q[i-1];
        end
        if (bus.flush) begin
            trk_valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= PORT0;
            trk_valid_q <= '0;
            trk_port_q  <= '0;
        end else begin
            last_q      <= last_d;
            trk_valid_q <= trk_valid_d;
            trk_port_q  <= trk_port_d;
        end
    end

    // Responses are masked while reset is held so stale entries never escape
    always_comb begin
        tail_valid     = trk_valid_q[SBOX_LAT-1] && !rst;
        bus.rsp0_valid = tail_valid && !trk_port_q[SBOX_LAT-1];
        bus.rsp1_valid = tail_valid &&  trk_port_q[SBOX_LAT-1];
        bus.rsp_data   = tail_valid ? bus.sbox_out : 8'h00;
        bus.busy       = (|trk_valid_q) && !rst;
    end

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Drives four arbiters (SBOX_LAT 1..4) with identical traffic and checks each
// one every cycle against a grant-queue model and an arithmetic AES S-box.
module tb_aes_sbox_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_inv;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_inv;
    logic       flush;

    logic [3:0] obs_r0;
    logic [3:0] obs_r1;
    logic [3:0] obs_sinv;
    logic [3:0] obs_p0;
    logic [3:0] obs_p1;
    logic [3:0] obs_busy;
    logic [7:0] obs_sin  [4];
    logic [7:0] obs_data [4];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    typedef struct {
        int         g;
        logic       port;
        logic [7:0] res;
        logic [3:0] alive;
    } item_t;

    item_t pend[$];
    logic  last_port = 1'b0;
    logic  held0 = 1'b0;
    logic  held1 = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < 254; k++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_fn(input logic [7:0] x, input logic inv);
        logic [7:0] y;
        if (inv) begin
            y = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
            return ginv(y);
        end
        y = ginv(x);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        localparam int LAT = i + 1;
        aes_sbox_arbiter_if bus ();
        logic [8:0] pipe [LAT];

        assign bus.req0_valid = req0_valid;
        assign bus.req0_data  = req0_data;
        assign bus.req0_inv   = req0_inv;
        assign bus.req1_valid = req1_valid;
        assign bus.req1_data  = req1_data;
        assign bus.req1_inv   = req1_inv;
        assign bus.flush      = flush;

        always @(posedge clk) begin
            pipe[0] <= {bus.sbox_inv, bus.sbox_in};
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign bus.sbox_out = sbox_fn(pipe[LAT-1][7:0], pipe[LAT-1][8]);

        assign obs_r0[i]   = bus.req0_ready;
        assign obs_r1[i]   = bus.req1_ready;
        assign obs_sin[i]  = bus.sbox_in;
        assign obs_sinv[i] = bus.sbox_inv;
        assign obs_p0[i]   = bus.rsp0_valid;
        assign obs_p1[i]   = bus.rsp1_valid;
        assign obs_data[i] = bus.rsp_data;
        assign obs_busy[i] = bus.busy;

        aes_sbox_arbiter #(.SBOX_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s lat=%0d cyc=%0d got %h want %h", name, idx + 1, cyc, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic       e_r0, e_r1, e_sinv, e_p0, e_p1, e_busy;
        logic [7:0] e_sin, e_data;
        item_t      it;
        int         lat;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!rst && !flush) begin
            if (req0_valid && req1_valid) begin
                if (last_port == 1'b0) e_r1 = 1'b1;
                else                   e_r0 = 1'b1;
            end else if (req0_valid) begin
                e_r0 = 1'b1;
            end else if (req1_valid) begin
                e_r1 = 1'b1;
            end
        end
        e_sin  = e_r0 ? req0_data : (e_r1 ? req1_data : 8'h00);
        e_sinv = e_r0 ? req0_inv  : (e_r1 ? req1_inv  : 1'b0);

        for (int j = 0; j < 4; j++) begin
            lat    = j + 1;
            e_p0   = 1'b0;
            e_p1   = 1'b0;
            e_busy = 1'b0;
            e_data = 8'h00;
            foreach (pend[k]) begin
                if (!rst && pend[k].alive[j]) begin
                    if (pend[k].g + lat == cyc) begin
                        e_p0   = !pend[k].port;
                        e_p1   = pend[k].port;
                        e_data = pend[k].res;
                    end
                    if (pend[k].g < cyc && cyc <= pend[k].g + lat) e_busy = 1'b1;
                end
            end
            chk("req0_ready", j, obs_r0[j],   e_r0);
            chk("req1_ready", j, obs_r1[j],   e_r1);
            chk("sbox_in",    j, obs_sin[j],  e_sin);
            chk("sbox_inv",   j, obs_sinv[j], e_sinv);
            chk("rsp0_valid", j, obs_p0[j],   e_p0);
            chk("rsp1_valid", j, obs_p1[j],   e_p1);
            chk("rsp_data",   j, obs_data[j], e_data);
            chk("busy",       j, obs_busy[j], e_busy);
        end

        if (rst) begin
            foreach (pend[k]) pend[k].alive = 4'b0000;
            last_port = 1'b0;
        end else begin
            if (flush) begin
                foreach (pend[k]) begin
                    for (int j = 0; j < 4; j++) begin
                        if (pend[k].g + j + 1 > cyc) pend[k].alive[j] = 1'b0;
                    end
                end
            end
            if (e_r0 || e_r1) begin
                it.g     = cyc;
                it.port  = e_r1;
                it.res   = sbox_fn(e_sin, e_sinv);
                it.alive = 4'b1111;
                pend.push_back(it);
                last_port = e_r1;
            end
        end
        while (pend.size() > 0 && pend[0].g + 5 < cyc) void'(pend.pop_front());
        held0 = req0_valid && !e_r0;
        held1 = req1_valid && !e_r1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic i0,
                                 input logic v1, input logic [7:0] d1, input logic i1,
                                 input logic fl, input logic rs);
        @(posedge clk);
        #1;
        req0_valid = v0;
        req0_data  = d0;
        req0_inv   = i0;
        req1_valid = v1;
        req1_data  = d1;
        req1_inv   = i1;
        flush      = fl;
        rst        = rs;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req0_inv   = 1'b0;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        req1_inv   = 1'b0;

        chk("model_sbox_fwd53", 0, sbox_fn(8'h53, 1'b0), 9'h0ED);
        chk("model_sbox_invED", 0, sbox_fn(8'hED, 1'b1), 9'h053);
        chk("model_sbox_fwd00", 0, sbox_fn(8'h00, 1'b0), 9'h063);

        for (int k = 0; k < 3; k++) applyStimulus(1, 8'hAA, 0, 1, 8'h55, 1, 0, 1);
        chk("reset_busy", 3, obs_busy[3], 0);
        chk("reset_sbox_in", 0, obs_sin[0], 9'h000);
        idle(1);

        // Single forward request on port 0
        applyStimulus(1, 8'h53, 0, 0, 8'h00, 0, 0, 0);
        idle(2);
        chk("single_rsp0", 1, obs_p0[1], 1);
        chk("single_rsp1", 1, obs_p1[1], 0);
        chk("single_data", 1, obs_data[1], 9'h0ED);
        idle(3);

        // Continuous tie after reset alternates starting with port 1
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 8'h10 + 8'(k), 0, 1, 8'h20 + 8'(k), 0, 0, 0);
            chk("tie_grant1", 0, obs_r1[0], (k % 2 == 0) ? 9'h001 : 9'h000);
        end
        idle(5);

        // Inverse request on port 1
        applyStimulus(0, 8'h00, 0, 1, 8'hED, 1, 0, 0);
        chk("inv_issue_sbox_inv", 1, obs_sinv[1], 1);
        idle(1);
        chk("inv_after_sbox_inv", 1, obs_sinv[1], 0);
        idle(1);
        chk("inv_rsp1", 1, obs_p1[1], 1);
        chk("inv_data", 1, obs_data[1], 9'h053);
        idle(3);

        // Three grants then flush
        for (int k = 0; k < 3; k++) applyStimulus(1, 8'h30 + 8'(k), 0, 0, 8'h00, 0, 0, 0);
        applyStimulus(1, 8'h77, 0, 1, 8'h78, 0, 1, 0);
        chk("flush_no_grant", 0, obs_r0[0] | obs_r1[0], 0);
        idle(1);
        chk("flush_busy_after", 3, obs_busy[3], 0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("flush_no_pulse", 3, obs_p0[3] | obs_p1[3], 0);
        end

        // Reset with operations in flight
        applyStimulus(1, 8'h41, 0, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 8'h42, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("rst_no_pulse", 3, obs_p0[3] | obs_p1[3], 0);
            chk("rst_busy", 3, obs_busy[3], 0);
        end
        applyStimulus(1, 8'h01, 0, 1, 8'h02, 0, 0, 0);
        chk("rst_first_tie", 0, obs_r1[0], 1);
        idle(5);

        // Random traffic; held requests stay valid with stable data
        for (int n = 0; n < 2000; n++) begin
            logic       v0, v1, i0, i1, fl, rs;
            logic [7:0] d0, d1;
            if (held0) begin
                v0 = 1'b1; d0 = req0_data; i0 = req0_inv;
            end else begin
                v0 = ($urandom_range(99) < 65); d0 = 8'($urandom); i0 = 1'($urandom);
            end
            if (held1) begin
                v1 = 1'b1; d1 = req1_data; i1 = req1_inv;
            end else begin
                v1 = ($urandom_range(99) < 65); d1 = 8'($urandom); i1 = 1'($urandom);
            end
            fl = ($urandom_range(99) < 3);
            rs = ($urandom_range(199) < 2);
            applyStimulus(v0, d0, i0, v1, d1, i1, fl, rs);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
